// File: rtl/dram_arbiter.sv
// dram_arbiter: two-port arbiter/sequencer for the single external DRAM channel.
// Port 0 = io block, port 1 = data_ram miss/write path. One access in flight at a time,
// with a watchdog that forces completion if ready_dram never arrives.
// Optional feature: define DRAM_ARB_RR_EN for round-robin arbitration
// (default build: fixed priority, port 0 wins).
module dram_arbiter #(
    parameter int ADDR_W         = 27,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid_0,
    input  logic              req_rw_0,
    input  logic [ADDR_W-1:0] req_addr_0,
    input  logic [31:0]       req_wdata_0,
    input  logic              req_valid_1,
    input  logic              req_rw_1,
    input  logic [ADDR_W-1:0] req_addr_1,
    input  logic [31:0]       req_wdata_1,
    output logic              done_0,
    output logic              done_1,
    output logic [31:0]       rdata_0,
    output logic [31:0]       rdata_1,
    output logic              valid_dram,
    output logic              rw_dram,
    output logic [ADDR_W-1:0] addr_dram,
    output logic [31:0]       din_dram,
    input  logic [31:0]       dout_dram,
    input  logic              ready_dram,
    output logic              busy,
    output logic              timeout_err
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] TO_LIMIT = CNT_W'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

    state_t            state_q, state_d;
    logic              owner_q, owner_d;
    logic              rw_q, rw_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              terr_q, terr_d;
    logic [31:0]       rdata0_q, rdata0_d;
    logic [31:0]       rdata1_q, rdata1_d;
    logic [CNT_W-1:0]  cnt_inc;
    logic              grant;
    logic              cap_en;
    logic [31:0]       cap_data;

`ifdef DRAM_ARB_RR_EN
    logic last_q, last_d;

    // Round-robin winner: on a tie, the port not granted last time wins.
    always_comb begin
        if (req_valid_0 && req_valid_1) grant = ~last_q;
        else                            grant = req_valid_1;
    end
`else
    // Fixed priority winner: port 0 always beats port 1.
    always_comb begin
        grant = ~req_valid_0;
    end
`endif

    assign cnt_inc = cnt_q + 1'b1;

    // Next-state, command latch, watchdog and read-data capture.
    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        rw_d     = rw_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        cnt_d    = cnt_q;
        terr_d   = terr_q;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        cap_en   = 1'b0;
        cap_data = 32'h0;
`ifdef DRAM_ARB_RR_EN
        last_d   = last_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (req_valid_0 || req_valid_1) begin
                    owner_d = grant;
                    rw_d    = grant ? req_rw_1    : req_rw_0;
                    addr_d  = grant ? req_addr_1  : req_addr_0;
                    wdata_d = grant ? req_wdata_1 : req_wdata_0;
`ifdef DRAM_ARB_RR_EN
                    last_d  = grant;
`endif
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (ready_dram) begin
                    cap_en   = 1'b1;
                    cap_data = dout_dram;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_inc;
                if (ready_dram) begin
                    cap_en   = 1'b1;
                    cap_data = dout_dram;
                end else if (cnt_inc == TO_LIMIT) begin
                    terr_d   = 1'b1;
                    cap_en   = 1'b1;
                    cap_data = 32'h0;
                end
            end
            S_DONE: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        // Read data is loaded on entry to DONE so it is already valid while done is high.
        if (cap_en) begin
            state_d = S_DONE;
            if (!rw_q) begin
                if (owner_q) rdata1_d = cap_data;
                else         rdata0_d = cap_data;
            end
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            owner_q  <= 1'b0;
            rw_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= 32'h0;
            cnt_q    <= '0;
            terr_q   <= 1'b0;
            rdata0_q <= 32'h0;
            rdata1_q <= 32'h0;
`ifdef DRAM_ARB_RR_EN
            last_q   <= 1'b1;
`endif
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            rw_q     <= rw_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            cnt_q    <= cnt_d;
            terr_q   <= terr_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
`ifdef DRAM_ARB_RR_EN
            last_q   <= last_d;
`endif
        end
    end

    assign valid_dram  = (state_q == S_ISSUE);
    assign done_0      = (state_q == S_DONE) && !owner_q;
    assign done_1      = (state_q == S_DONE) &&  owner_q;
    assign busy        = (state_q != S_IDLE);
    assign rw_dram     = rw_q;
    assign addr_dram   = addr_q;
    assign din_dram    = wdata_q;
    assign rdata_0     = rdata0_q;
    assign rdata_1     = rdata1_q;
    assign timeout_err = terr_q;

endmodule

// File: tb/tb_dram_arbiter.sv
// Scoreboard bench for dram_arbiter: stimulus pushes expected commands and completions,
// monitors pop and compare whenever valid_dram or done_* is seen.
module tb_dram_arbiter;

    localparam int AW = 27;
    localparam int TO = 8;

    typedef struct {bit rw; logic [AW-1:0] addr; logic [31:0] din; int cyc;} cmd_t;
    typedef struct {bit port; logic [31:0] rdata; logic [AW-1:0] addr; int cyc;} done_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid_0 = 1'b0, req_rw_0 = 1'b0;
    logic [AW-1:0] req_addr_0 = '0;
    logic [31:0]   req_wdata_0 = 32'h0;
    logic          req_valid_1 = 1'b0, req_rw_1 = 1'b0;
    logic [AW-1:0] req_addr_1 = '0;
    logic [31:0]   req_wdata_1 = 32'h0;
    logic          done_0, done_1, valid_dram, rw_dram, busy, timeout_err;
    logic [31:0]   rdata_0, rdata_1, din_dram, dout_dram;
    logic [AW-1:0] addr_dram;
    logic          ready_dram;
    logic          ready_man = 1'b0, auto_rdy = 1'b0;
    logic [31:0]   man_dout = 32'h0;

    int    checks = 0, errors = 0, cyc = 0;
    cmd_t  cq[$];
    done_t dq[$];
    logic [31:0] model_rd [2];

    // Auto-responder answers in the ISSUE cycle with data derived from the address.
    assign ready_dram = ready_man | (auto_rdy & valid_dram);
    assign dout_dram  = auto_rdy ? (32'hA5A5_0000 ^ {5'h0, addr_dram}) : man_dout;

    dram_arbiter #(.ADDR_W(AW), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst),
        .req_valid_0(req_valid_0), .req_rw_0(req_rw_0), .req_addr_0(req_addr_0), .req_wdata_0(req_wdata_0),
        .req_valid_1(req_valid_1), .req_rw_1(req_rw_1), .req_addr_1(req_addr_1), .req_wdata_1(req_wdata_1),
        .done_0(done_0), .done_1(done_1), .rdata_0(rdata_0), .rdata_1(rdata_1),
        .valid_dram(valid_dram), .rw_dram(rw_dram), .addr_dram(addr_dram), .din_dram(din_dram),
        .dout_dram(dout_dram), .ready_dram(ready_dram), .busy(busy), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] auto_data(input logic [AW-1:0] a);
        return 32'hA5A5_0000 ^ {5'h0, a};
    endfunction

    function automatic void push_cmd(input bit rw, input logic [AW-1:0] a, input logic [31:0] d, input int c);
        cmd_t e;
        e.rw = rw; e.addr = a; e.din = d; e.cyc = c;
        cq.push_back(e);
    endfunction

    // Writes keep the port's previous read data; reads replace it.
    function automatic void push_done(input bit p, input bit rw, input logic [AW-1:0] a,
                                      input logic [31:0] d, input int c);
        done_t e;
        e.port = p; e.addr = a; e.cyc = c;
        e.rdata = rw ? model_rd[p] : d;
        model_rd[p] = e.rdata;
        dq.push_back(e);
    endfunction

    // Command monitor.
    always @(negedge clk) begin
        if (!rst && valid_dram) begin
            if (cq.size() == 0) begin
                chk("unexpected_valid_dram", 1, 0);
            end else begin
                cmd_t e;
                e = cq.pop_front();
                chk("cmd_rw", rw_dram, e.rw);
                chk("cmd_addr", addr_dram, e.addr);
                chk("cmd_din", din_dram, e.din);
                chk("cmd_cycle", cyc, e.cyc);
            end
        end
    end

    // Completion monitor.
    always @(negedge clk) begin
        if (!rst) begin
            if (done_0 && done_1) chk("done_both", 1, 0);
            else if (done_0 || done_1) begin
                if (dq.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    done_t e;
                    e = dq.pop_front();
                    chk("done_port", done_1, e.port);
                    chk("done_rdata", done_1 ? rdata_1 : rdata_0, e.rdata);
                    chk("done_addr_stable", addr_dram, e.addr);
                    chk("done_cycle", cyc, e.cyc);
                end
            end
        end
    end

    task automatic chk_idle(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done0"}, done_0, 0);
        chk({tag, "_done1"}, done_1, 0);
        chk({tag, "_valid_dram"}, valid_dram, 0);
        chk({tag, "_rw_dram"}, rw_dram, 0);
        chk({tag, "_addr_dram"}, addr_dram, 0);
        chk({tag, "_din_dram"}, din_dram, 0);
        chk({tag, "_rdata0"}, rdata_0, 0);
        chk({tag, "_rdata1"}, rdata_1, 0);
        chk({tag, "_timeout_err"}, timeout_err, 0);
    endtask

    task automatic wait_done(input bit p);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (p ? done_1 : done_0) return;
        end
        chk(p ? "wait_done1_timeout" : "wait_done0_timeout", 1, 0);
    endtask

    task automatic set_req(input bit p, input bit rw, input logic [AW-1:0] a, input logic [31:0] d);
        if (p) begin req_valid_1 = 1; req_rw_1 = rw; req_addr_1 = a; req_wdata_1 = d; end
        else   begin req_valid_0 = 1; req_rw_0 = rw; req_addr_0 = a; req_wdata_0 = d; end
    endtask

    // Single scripted access with manual ready; dly = cycles after valid_dram, -1 = never.
    task automatic access(input bit p, input bit rw, input logic [AW-1:0] a, input logic [31:0] wd,
                          input int dly, input logic [31:0] dout);
        int c;
        @(posedge clk); #1;
        c = cyc;
        set_req(p, rw, a, wd);
        push_cmd(rw, a, wd, c + 1);
        if (dly >= 0) begin
            push_done(p, rw, a, dout, c + 2 + dly);
            repeat (1 + dly) @(posedge clk);
            #1 ready_man = 1; man_dout = dout;
            @(posedge clk); #1 ready_man = 0;
        end else begin
            push_done(p, rw, a, 32'h0, c + 2 + TO);
            repeat (2 + TO) @(posedge clk);
            #1;
        end
        @(posedge clk); #1;
        if (p) req_valid_1 = 0; else req_valid_0 = 0;
    endtask

    initial begin
        int c;
        model_rd[0] = 32'h0;
        model_rd[1] = 32'h0;
        repeat (2) @(negedge clk);
        chk_idle("in_reset");
        @(posedge clk); #1 rst = 0;
        @(negedge clk);
        chk_idle("post_reset");

        // Both ports compete; port 0 wants two accesses (A then B), port 1 one (C).
        @(posedge clk); #1;
        c = cyc;
        auto_rdy = 1;
        set_req(0, 0, 27'h10, 32'h0);
        set_req(1, 0, 27'h30, 32'h3);
        push_cmd(0, 27'h10, 32'h0, c + 1);
        push_done(0, 0, 27'h10, auto_data(27'h10), c + 2);
`ifdef DRAM_ARB_RR_EN
        push_cmd(0, 27'h30, 32'h3, c + 4);
        push_done(1, 0, 27'h30, auto_data(27'h30), c + 5);
        push_cmd(0, 27'h20, 32'h0, c + 7);
        push_done(0, 0, 27'h20, auto_data(27'h20), c + 8);
`else
        push_cmd(0, 27'h20, 32'h0, c + 4);
        push_done(0, 0, 27'h20, auto_data(27'h20), c + 5);
        push_cmd(0, 27'h30, 32'h3, c + 7);
        push_done(1, 0, 27'h30, auto_data(27'h30), c + 8);
`endif
        fork
            begin
                wait_done(0);
                @(posedge clk); #1 req_addr_0 = 27'h20;
                wait_done(0);
                @(posedge clk); #1 req_valid_0 = 0;
            end
            begin
                wait_done(1);
                @(posedge clk); #1 req_valid_1 = 0;
            end
        join
        #1 auto_rdy = 0;
        repeat (2) @(posedge clk);

        // Read on port 1, ready two cycles after valid_dram.
        access(1, 0, 27'h100, 32'h1111, 2, 32'hCAFE0001);
        repeat (2) @(posedge clk);
        // Write on port 0 completed in the ISSUE cycle; rdata_0 must be unchanged.
        access(0, 1, 27'h4, 32'h12345678, 0, 32'hFFFF_FFFF);
        repeat (2) @(posedge clk);
        // Watchdog: ready never arrives, read data forced to zero.
        access(0, 0, 27'h40, 32'h0, -1, 32'h0);
        @(negedge clk);
        chk("timeout_err_set", timeout_err, 1);
        repeat (5) @(negedge clk);
        chk("timeout_err_sticky", timeout_err, 1);
        chk("timeout_rdata0_held", rdata_0, 32'h0);

        // Reset in the middle of WAIT abandons the access.
        @(posedge clk); #1;
        c = cyc;
        set_req(1, 0, 27'h55, 32'h77);
        push_cmd(0, 27'h55, 32'h77, c + 1);
        repeat (3) @(posedge clk);
        #1 rst = 1; req_valid_1 = 0;
        @(posedge clk); #1 rst = 0;
        model_rd[0] = 32'h0;
        model_rd[1] = 32'h0;
        @(negedge clk);
        chk_idle("mid_wait_reset");
        @(posedge clk); #1 ready_man = 1; man_dout = 32'hBAD0BAD0;
        @(posedge clk); #1 ready_man = 0;
        repeat (3) @(negedge clk);
        chk("stray_ready_busy", busy, 0);

        // Normal access afterwards, top address, ready one cycle after valid_dram.
        access(1, 0, 27'h7FF_FFFF, 32'h0, 1, 32'hDEADBEEF);
        repeat (3) @(negedge clk);
        chk("timeout_err_clear", timeout_err, 0);
        chk("cmd_queue_empty", cq.size(), 0);
        chk("done_queue_empty", dq.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global watchdog so the bench can never hang.
    initial begin
        #100000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "bench timeout");
    end

endmodule
